// File: rtl/muldiv_sequencer_pkg.sv
// Shared M-extension encodings and sequencer state type.
package muldiv_sequencer_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with sign fixup and result mux.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  logic            fast,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] fast_val,
    output logic [XLEN-1:0] result
);

    logic [2:0]        f3_q, f3_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              fast_q, fast_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;

    logic              signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod, prod_neg;
    logic [XLEN-1:0]   quo, rem, res;

    // Operand magnitudes on load, and one multiply or divide iteration per step.
    always_comb begin
        signed_a = (funct3 != FUNCT3_MULHU) && (funct3 != FUNCT3_DIVU) &&
                   (funct3 != FUNCT3_REMU);
        signed_b = signed_a && (funct3 != FUNCT3_MULHSU);
        a_neg    = signed_a && op_a[XLEN-1];
        b_neg    = signed_b && op_b[XLEN-1];
        mag_a    = a_neg ? ('0 - op_a) : op_a;
        mag_b    = b_neg ? ('0 - op_b) : op_b;

        // Multiplier sits in the low half and shifts out as the partial sum shifts in.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Remainder gets one extra bit after the shift; a borrow means restore.
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = {1'b0, rem_sh} - {2'b00, mcand_q};
        div_next = diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        f3_d    = f3_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        fast_d  = fast_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        if (load) begin
            f3_d    = funct3;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            fast_d  = fast;
            if (fast) begin
                acc_d   = {{XLEN{1'b0}}, fast_val};
                mcand_d = '0;
            end else if (funct3[2]) begin
                acc_d   = {{XLEN{1'b0}}, mag_a};
                mcand_d = mag_b;
            end else begin
                acc_d   = {{XLEN{1'b0}}, mag_b};
                mcand_d = mag_a;
            end
        end else if (step) begin
            acc_d = f3_q[2] ? div_next : mul_next;
        end
    end

    // Sign fixup and result select; the output is forced to 0 outside the done cycle.
    always_comb begin
        prod_neg = '0 - acc_q;
        prod     = (a_neg_q ^ b_neg_q) ? prod_neg : acc_q;
        quo      = (a_neg_q ^ b_neg_q) ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem      = a_neg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        if (fast_q) begin
            res = acc_q[XLEN-1:0];
        end else begin
            unique case (f3_q)
                FUNCT3_MUL:                 res = prod[XLEN-1:0];
                FUNCT3_DIV, FUNCT3_DIVU:    res = quo;
                FUNCT3_REM, FUNCT3_REMU:    res = rem;
                default:                    res = prod[2*XLEN-1:XLEN];
            endcase
        end
        result = finish ? res : '0;
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            f3_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            fast_q  <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            f3_q    <= f3_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            fast_q  <= fast_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// M-extension sequencer: FSM, iteration counter, fast-path detect, stall/done.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             load, step, fast, div_zero, ovf;
    logic [XLEN-1:0]  fast_val;

    // Next state, strobes and the combinational stall.
    always_comb begin
        div_zero = funct3[2] && (op_b == '0);
        ovf      = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (op_b == '1);
        fast     = div_zero || ovf;
        if (div_zero) begin
            fast_val = funct3[1] ? op_a : '1;
        end else begin
            fast_val = funct3[1] ? '0 : op_a;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    stall   = 1'b1;
                    cnt_d   = '0;
                    state_d = fast ? MD_DONE : MD_RUN;
                end
            end
            MD_RUN: begin
                if (flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    step  = 1'b1;
                    stall = 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = MD_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            MD_DONE: begin
                // start here is the same instruction leaving EX.
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
        done_d = (state_d == MD_DONE);
    end

    // FSM state, counter and registered done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .finish   (done_q),
        .fast     (fast),
        .funct3   (funct3),
        .op_a     (op_a),
        .op_b     (op_b),
        .fast_val (fast_val),
        .result   (result)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op at cycle 0, hold start until done, check latency/result/stall.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        bit seen;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        chk({tag, " stall0"}, {31'd0, stall}, 32'd1);
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                chk({tag, " lat"}, 32'(k), 32'(exp_lat));
                chk({tag, " result"}, result, exp);
                chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
                start = 1'b0;
            end else begin
                chk({tag, " stall_run"}, {31'd0, stall}, 32'd1);
                if (k == 1) chk({tag, " result_idle"}, result, 32'd0);
            end
        end
        if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " done_after"}, {31'd0, done}, 32'd0);
    endtask

    // Count done pulses over a window with start low.
    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        int lat;
        bit seen;
        reset  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst result", result, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Flush at cycle 10 of a running divide.
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        start  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        chk("flush stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush done", {31'd0, done}, 32'd0);
        chk("flush stall_idle", {31'd0, stall}, 32'd0);
        count_dones(40, n);
        chk("flush no_done", 32'(n), 32'd0);
        run_op("after_flush", 3'b000, 32'd6, 32'd9, 32'd54, 33);

        // Reset at cycle 20 of a running multiply.
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd5;
        start  = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rstrun stall", {31'd0, stall}, 32'd0);
        chk("rstrun done", {31'd0, done}, 32'd0);
        chk("rstrun result", result, 32'd0);
        reset = 1'b1;
        count_dones(40, n);
        chk("rstrun no_done", 32'(n), 32'd0);
        run_op("after_rst", 3'b111, 32'd100, 32'd9, 32'd1, 33);

        // Back-to-back with start held through DONE.
        funct3 = 3'b011;
        op_a   = 32'hFFFF_FFFF;
        op_b   = 32'hFFFF_FFFF;
        start  = 1'b1;
        seen   = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk("b2b first lat", 32'(lat), 32'd33);
        chk("b2b first result", result, 32'hFFFF_FFFE);
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        @(posedge clk);
        #1;
        chk("b2b accept done", {31'd0, done}, 32'd0);
        chk("b2b accept stall", {31'd0, stall}, 32'd1);
        seen = 1'b0;
        lat  = 0;
        n    = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = k;
                n++;
            end
        end
        chk("b2b second lat", 32'(lat), 32'd33);
        chk("b2b second result", result, 32'd14);
        chk("b2b second count", 32'(n), 32'd1);
        start = 1'b0;
        count_dones(40, n);
        chk("b2b no_extra", 32'(n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
